alu_issue_ctrl: RTL and testbench

Sequencer and two-port arbiter that shares the PE's single registered 32-bit ALU between two requesters: port 0 is the local instruction pipeline, port 1 is the CGRA neighbour/route request path. It accepts one operation at a time through a valid/ready handshake, drives the ALU operand and select lines, and captures the result one cycle later. It computes its own zero flag from the captured result, flags illegal opcodes and divide-by-zero, and returns a tagged response on the originating port. It sits between the PE decode/route logic and the `alu` instance.

---
 rtl/alu_issue_ctrl_pkg.sv | 23 ++
 rtl/alu_issue_ctrl_if.sv | 29 ++
 rtl/alu_issue_ctrl_rr_arbiter2.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, legal range, FSM states.
package alu_issue_ctrl_pkg;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_MUL   = 5'd2;
   localparam logic [4:0] ALU_DIV   = 5'd3;
   localparam logic [4:0] ALU_ZEXTH = 5'd19;

   localparam int ALU_OP_MAX = 19;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

   function automatic logic [1:0] port_onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response bus between the two requesters and the ALU issue controller.
interface alu_issue_ctrl_if #(
   parameter int TAG_W = 4
) ();

   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [63:0]        req_a;
   logic [63:0]        req_b;
   logic [9:0]         req_op;
   logic [2*TAG_W-1:0] req_tag;
   logic [1:0]         resp_valid;
   logic [1:0]         resp_ready;
   logic [31:0]        resp_result;
   logic               resp_zero;
   logic               resp_err;
   logic [TAG_W-1:0]   resp_tag;

   modport master (
      output req_valid, req_a, req_b, req_op, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_zero, resp_err, resp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_tag, resp_ready,
      output req_ready, resp_valid, resp_result, resp_zero, resp_err, resp_tag
   );

endinterface

// File: rtl/alu_issue_ctrl_rr_arbiter2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last. The last-winner register moves only on the update strobe.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_port,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   logic last_q, last_d;

   // Grant selection and last-winner update
   always_comb begin
      last_d  = upd ? upd_port : last_q;
      gnt_idx = 1'b0;
      case (req)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last_q;
         default: gnt_idx = 1'b0;
      endcase
      gnt = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
   end

   // Last winner resets to port 1 so port 0 takes the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer/arbiter sharing one registered ALU between the local pipeline
// (port 0) and the CGRA route path (port 1); one operation in flight at a time.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int TAG_W  = 4,
   parameter int OP_MAX = ALU_OP_MAX
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_issue_ctrl_if.slave    bus,
   output logic [31:0]        alu_a,
   output logic [31:0]        alu_b,
   output logic [4:0]         alu_sel,
   input  logic [31:0]        alu_out,
   output logic               busy
);

   state_t           state_q, state_d;
   logic             port_q, port_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      alu_a_q, alu_a_d;
   logic [31:0]      alu_b_q, alu_b_d;
   logic [4:0]       alu_sel_q, alu_sel_d;
   logic [31:0]      result_q, result_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic [1:0]       resp_valid_q, resp_valid_d;
   logic             busy_q, busy_d;

   logic             g;
   logic [1:0]       gnt;
   logic             resp_fire;
   logic [31:0]      sel_a, sel_b;
   logic [4:0]       sel_op;
   logic [TAG_W-1:0] sel_tag;

   assign resp_fire = (state_q == RESP) && bus.resp_ready[port_q];

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (bus.req_valid),
      .upd      (resp_fire),
      .upd_port (port_q),
      .gnt      (gnt),
      .gnt_idx  (g)
   );

   assign sel_a   = g ? bus.req_a[63:32] : bus.req_a[31:0];
   assign sel_b   = g ? bus.req_b[63:32] : bus.req_b[31:0];
   assign sel_op  = g ? bus.req_op[9:5]  : bus.req_op[4:0];
   assign sel_tag = g ? bus.req_tag[2*TAG_W-1:TAG_W] : bus.req_tag[TAG_W-1:0];

   // Ready is gated by reset so it reads 0 while rst_n is held low
   assign bus.req_ready   = (rst_n && state_q == IDLE) ? gnt : 2'b00;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = result_q;
   assign bus.resp_zero   = zero_q;
   assign bus.resp_err    = err_q;
   assign bus.resp_tag    = tag_q;
   assign alu_a           = alu_a_q;
   assign alu_b           = alu_b_q;
   assign alu_sel         = alu_sel_q;
   assign busy            = busy_q;

   // Next-state and registered-output computation
   always_comb begin
      state_d      = state_q;
      port_d       = port_q;
      tag_d        = tag_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      result_d     = result_q;
      zero_d       = zero_q;
      err_d        = err_q;
      resp_valid_d = resp_valid_q;
      busy_d       = busy_q;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               port_d = g;
               tag_d  = sel_tag;
               busy_d = 1'b1;
               if (sel_op > 5'(OP_MAX)) begin
                  state_d      = RESP;
                  result_d     = '0;
                  zero_d       = 1'b1;
                  err_d        = 1'b1;
                  resp_valid_d = port_onehot(g);
               end else begin
                  // ALU operand flops double as the operand hold registers
                  state_d   = EXEC;
                  alu_a_d   = sel_a;
                  alu_b_d   = sel_b;
                  alu_sel_d = sel_op;
               end
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            state_d      = RESP;
            result_d     = alu_out;
            zero_d       = (alu_out == '0);
            err_d        = (alu_sel_q == ALU_DIV) && (alu_b_q == '0);
            resp_valid_d = port_onehot(port_q);
         end
         RESP: begin
            if (resp_fire) begin
               state_d      = IDLE;
               resp_valid_d = '0;
               busy_d       = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops any in-flight response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         port_q       <= 1'b0;
         tag_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
         err_q        <= 1'b0;
         resp_valid_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         port_q       <= port_d;
         tag_q        <= tag_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         err_q        <= err_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural registered ALU, vector table,
// scoreboard on the response handshake, and hand-written multi-cycle sequences.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   localparam int TAG_W = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_sel;
   logic [31:0] alu_out = '0;
   logic        busy;

   alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

   alu_issue_ctrl #(.TAG_W(TAG_W), .OP_MAX(19)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_sel (alu_sel),
      .alu_out (alu_out),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [4:0] sel);
      case (sel)
         5'd0:    return a + b;
         5'd1:    return a - b;
         5'd2:    return a * b;
         5'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd19:   return {16'h0000, a[15:0]};
         default: return a ^ b;
      endcase
   endfunction

   // Behavioural registered ALU
   always @(posedge clk) alu_out <= alu_fn(alu_a, alu_b, alu_sel);

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout (t=%0t)", name, $time);
   endtask

   typedef struct {
      logic             port;
      logic [31:0]      result;
      logic             zero;
      logic             err;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t sbq[$];

   // Scoreboard push: on every request handshake, predict the response
   always @(negedge clk) begin
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if (bus.req_valid[p] && bus.req_ready[p]) begin
               exp_t        e;
               logic [31:0] a, b;
               logic [4:0]  op;
               a  = bus.req_a[32*p +: 32];
               b  = bus.req_b[32*p +: 32];
               op = bus.req_op[5*p +: 5];
               e.port = p[0];
               e.tag  = bus.req_tag[TAG_W*p +: TAG_W];
               if (op > 5'd19) begin
                  e.result = '0;
                  e.err    = 1'b1;
               end else begin
                  e.result = alu_fn(a, b, op);
                  e.err    = (op == 5'd3) && (b == 0);
               end
               e.zero = (e.result == 0);
               sbq.push_back(e);
            end
         end
      end
   end

   // Scoreboard pop: compare on every response handshake
   always @(negedge clk) begin
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if (bus.resp_valid[p] && bus.resp_ready[p]) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: response on port %0d with empty scoreboard", p);
               end else begin
                  exp_t e;
                  e = sbq.pop_front();
                  chk("sb_port",   32'(p),               32'(e.port));
                  chk("sb_result", bus.resp_result,      e.result);
                  chk("sb_zero",   32'(bus.resp_zero),   32'(e.zero));
                  chk("sb_err",    32'(bus.resp_err),    32'(e.err));
                  chk("sb_tag",    32'(bus.resp_tag),    32'(e.tag));
               end
            end
         end
      end
   end

   task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] op, input logic [TAG_W-1:0] tag);
      bus.req_a[32*p +: 32]      = a;
      bus.req_b[32*p +: 32]      = b;
      bus.req_op[5*p +: 5]       = op;
      bus.req_tag[TAG_W*p +: TAG_W] = tag;
      bus.req_valid[p]           = 1'b1;
   endtask

   // Waits for the grant, lets the handshake edge pass, then drops valid
   task automatic wait_accept(input int p);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (bus.req_ready[p]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("accept");
      @(posedge clk);
      #1;
      bus.req_valid[p] = 1'b0;
   endtask

   // Number of falling edges after the accept edge until resp_valid[p] is seen
   task automatic wait_resp(input int p, output int lat);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.resp_valid[p]) begin
            lat = n;
            break;
         end
      end
      if (lat == 0) fail_now("resp");
   endtask

   typedef struct {
      int               port;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [4:0]       op;
      logic [TAG_W-1:0] tag;
      logic [31:0]      result;
      logic             zero;
      logic             err;
      int               lat;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [4:0]  sel_before;
      logic [1:0]  exp_gnt [3];
      bit          ok;

      tbl[0] = '{0, 32'd5,   32'd7, 5'd0,  4'd3,  32'd12,         1'b0, 1'b0, 3};
      tbl[1] = '{1, 32'd100, 32'd0, 5'd3,  4'd5,  32'hFFFF_FFFF,  1'b0, 1'b1, 3};
      tbl[2] = '{0, 32'd8,   32'd8, 5'd25, 4'd7,  32'd0,          1'b1, 1'b1, 1};
      tbl[3] = '{1, 32'd10,  32'd3, 5'd1,  4'd1,  32'd7,          1'b0, 1'b0, 3};
      tbl[4] = '{0, 32'd20,  32'd5, 5'd3,  4'd2,  32'd4,          1'b0, 1'b0, 3};
      tbl[5] = '{1, 32'd6,   32'd7, 5'd2,  4'd15, 32'd42,         1'b0, 1'b0, 3};
      tbl[6] = '{0, 32'd1,   32'd1, 5'd1,  4'd6,  32'd0,          1'b1, 1'b0, 3};
      tbl[7] = '{1, 32'd4,   32'd4, 5'd20, 4'd9,  32'd0,          1'b1, 1'b1, 1};
      tbl[8] = '{0, 32'h1234_ABCD, 32'd0, 5'd19, 4'd12, 32'h0000_ABCD, 1'b0, 1'b0, 3};
      tbl[9] = '{1, 32'd1,   32'd2, 5'd31, 4'd11, 32'd0,          1'b1, 1'b1, 1};
      exp_gnt = '{2'b01, 2'b10, 2'b01};

      bus.req_valid  = 2'b00;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_op     = '0;
      bus.req_tag    = '0;
      bus.resp_ready = 2'b11;

      // Reset state, with both requesters asserting valid
      #2 bus.req_valid = 2'b11;
      #10;
      chk("rst_req_ready",   32'(bus.req_ready),  32'd0);
      chk("rst_resp_valid",  32'(bus.resp_valid), 32'd0);
      chk("rst_busy",        32'(busy),           32'd0);
      chk("rst_alu_a",       alu_a,               32'd0);
      chk("rst_alu_sel",     32'(alu_sel),        32'd0);
      chk("rst_resp_result", bus.resp_result,     32'd0);
      chk("rst_resp_err",    32'(bus.resp_err),   32'd0);
      bus.req_valid = 2'b00;
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven single transactions
      for (int i = 0; i < 10; i++) begin
         sel_before = alu_sel;
         drive_req(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag);
         wait_accept(tbl[i].port);
         wait_resp(tbl[i].port, lat);
         chk($sformatf("v%0d_lat", i),    32'(lat),             32'(tbl[i].lat));
         chk($sformatf("v%0d_valid", i),  32'(bus.resp_valid),  32'(port_onehot(tbl[i].port[0])));
         chk($sformatf("v%0d_result", i), bus.resp_result,      tbl[i].result);
         chk($sformatf("v%0d_zero", i),   32'(bus.resp_zero),   32'(tbl[i].zero));
         chk($sformatf("v%0d_err", i),    32'(bus.resp_err),    32'(tbl[i].err));
         chk($sformatf("v%0d_tag", i),    32'(bus.resp_tag),    32'(tbl[i].tag));
         chk($sformatf("v%0d_busy", i),   32'(busy),            32'd1);
         if (tbl[i].op > 5'd19)
            chk($sformatf("v%0d_alu_sel_held", i), 32'(alu_sel), 32'(sel_before));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1;

      // Response stall: port 0 held in RESP while port 1 waits
      bus.resp_ready = 2'b00;
      drive_req(0, 32'd1, 32'd2, 5'd0, 4'd4);
      wait_accept(0);
      drive_req(1, 32'd3, 32'd4, 5'd0, 4'd9);
      wait_resp(0, lat);
      chk("stall_lat", 32'(lat), 32'd3);
      for (int n = 0; n < 10; n++) begin
         chk("stall_valid",  32'(bus.resp_valid), 32'd1);
         chk("stall_result", bus.resp_result,     32'd3);
         chk("stall_tag",    32'(bus.resp_tag),   32'd4);
         chk("stall_ready",  32'(bus.req_ready),  32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.resp_ready = 2'b11;
      @(negedge clk);
      @(negedge clk);
      chk("stall_release_grant", 32'(bus.req_ready), 32'b10);
      @(posedge clk);
      #1;
      bus.req_valid[1] = 1'b0;
      wait_resp(1, lat);
      chk("stall_p1_lat", 32'(lat), 32'd3);
      chk("stall_p1_result", bus.resp_result, 32'd7);
      @(posedge clk);
      #1;

      // Serve port 0 so the pointer favours port 1, then reset mid-operation
      drive_req(0, 32'd2, 32'd2, 5'd0, 4'd0);
      wait_accept(0);
      wait_resp(0, lat);
      @(posedge clk);
      #1;
      drive_req(1, 32'd50, 32'd1, 5'd0, 4'd8);
      wait_accept(1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("capt_rst_busy",       32'(busy),            32'd0);
      chk("capt_rst_resp_valid", 32'(bus.resp_valid),  32'd0);
      chk("capt_rst_alu_a",      alu_a,                32'd0);
      chk("capt_rst_alu_b",      alu_b,                32'd0);
      chk("capt_rst_result",     bus.resp_result,      32'd0);
      chk("capt_rst_tag",        32'(bus.resp_tag),    32'd0);
      sbq.delete();
      @(posedge clk);
      #1;
      chk("capt_rst_no_resp", 32'(bus.resp_valid), 32'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Both ports contending after reset: grants alternate starting at port 0
      drive_req(0, 32'd9, 32'd9, 5'd1, 4'd1);
      drive_req(1, 32'd9, 32'd9, 5'd1, 4'd2);
      for (int k = 0; k < 3; k++) begin
         ok = 1'b0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) fail_now("tie_grant");
         chk($sformatf("tie%0d_grant", k), 32'(bus.req_ready), 32'(exp_gnt[k]));
         @(posedge clk);
         #1;
         ok = 1'b0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.resp_valid != 2'b00) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) fail_now("tie_resp");
         chk($sformatf("tie%0d_valid", k),  32'(bus.resp_valid), 32'(exp_gnt[k]));
         chk($sformatf("tie%0d_result", k), bus.resp_result,     32'd0);
         chk($sformatf("tie%0d_zero", k),   32'(bus.resp_zero),  32'd1);
         @(posedge clk);
         #1;
      end
      bus.req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
